// File: rtl/regfile_pkg.sv
// Shared widths and types for the register file and its datapath neighbours.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, x0 forcing, reset forcing.
// Optional same-cycle write bypass when REGFILE_BYPASS_EN is defined.
module regfile_read_port #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              rst,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] data_o
);
    import regfile_pkg::*;

    logic is_zero;

    assign is_zero = (addr_i == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    logic hit;

    assign hit = we_i && (addr_i == waddr_i);
`else
    logic unused_ok;

    assign unused_ok = &{1'b0, we_i, waddr_i, wdata_i};
`endif

    always_comb begin
        data_o = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
        if (hit) begin
            data_o = wdata_i;
        end
`endif
        // x0 and reset override everything, including the bypass
        if (rst || is_zero) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32x32 register file: two datapath read ports, one debug port, one write.
// Define REGFILE_BYPASS_EN for write-first reads in the write cycle.
module register_file #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import regfile_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en;

    assign wr_en = reg_write && (write_addr != ADDR_W'(ZERO_REG));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[write_addr] = write_data;
        end
    end

    // Flops rather than RAM so reset can clear every entry at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rp1 (
        .rst    (rst),
        .regs_i (regs_q),
        .addr_i (read_addr_1),
        .we_i   (reg_write),
        .waddr_i(write_addr),
        .wdata_i(write_data),
        .data_o (read_data_1)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rp2 (
        .rst    (rst),
        .regs_i (regs_q),
        .addr_i (read_addr_2),
        .we_i   (reg_write),
        .waddr_i(write_addr),
        .wdata_i(write_data),
        .data_o (read_data_2)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W)
    ) u_rpd (
        .rst    (rst),
        .regs_i (regs_q),
        .addr_i (dbg_addr),
        .we_i   (reg_write),
        .waddr_i(write_addr),
        .wdata_i(write_data),
        .data_o (dbg_data)
    );

endmodule
